// File: rtl/ddr4_dq_dir_ctrl_if.sv
// Direction-control bundle between the DQS direction detector and the
// DQ/DQS/DM pass-through buffer enables. The detector side is the master and
// the controller is the slave.
interface ddr4_dq_dir_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             wr_drive;
    logic             rd_drive;
    logic             wr_en;
    logic             rd_en;
    logic             dir_busy;
    logic             conflict;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output wr_drive, rd_drive,
        input  wr_en, rd_en, dir_busy, conflict, conflict_cnt
    );

    modport slave (
        input  wr_drive, rd_drive,
        output wr_en, rd_en, dir_busy, conflict, conflict_cnt
    );
endinterface

// File: rtl/ddr4_dq_dir_ctrl.sv
// Registered DQ direction controller for the DDR4 RDIMM simulation wrapper.
// It synchronizes the detector's wr/rd flags and grants glitch-free, mutually
// exclusive buffer enables. Each burst is stretched by a postamble hold, and
// a dead-time turnaround is enforced after every burst.
// Optional feature macro: DDR4_DIR_CTRL_CONFLICT_CNT_EN. It enables the
// saturating conflict-episode counter; when the macro is undefined, the
// counter output is tied to zero.
module ddr4_dq_dir_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    ddr4_dq_dir_ctrl_if.slave  bus
);
    localparam int unsigned MAXC = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int unsigned CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TURN_LD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_ACT,
        WR_HOLD,
        RD_ACT,
        RD_HOLD,
        TURN
    } state_t;

    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic                   wr_s;
    logic                   rd_s;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic wr_en_q;
    logic rd_en_q;
    logic busy_q;
    logic conflict_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronizer chains for the asynchronous detector flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync[0] <= bus.wr_drive;
            rd_sync[0] <= bus.rd_drive;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                wr_sync[i] <= wr_sync[i-1];
                rd_sync[i] <= rd_sync[i-1];
            end
        end
    end

    assign wr_s = wr_sync[SYNC_STAGES-1];
    assign rd_s = rd_sync[SYNC_STAGES-1];

    // Next-state and counter logic. At the end of a burst, go to TURN, or
    // skip TURN entirely when no dead time is configured.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (wr_s && !rd_s) begin
                    state_n = WR_ACT;
                end else if (rd_s && !wr_s) begin
                    state_n = RD_ACT;
                end
            end
            WR_ACT: begin
                if (!wr_s) begin
                    if (HOLD_CYCLES > 0) begin
                        state_n = WR_HOLD;
                        cnt_n   = HOLD_LD;
                    end else begin
                        state_n = (TURN_CYCLES > 0) ? TURN : IDLE;
                        cnt_n   = TURN_LD;
                    end
                end
            end
            WR_HOLD: begin
                if (wr_s && !rd_s) begin
                    state_n = WR_ACT;
                end else if (cnt == '0) begin
                    state_n = (TURN_CYCLES > 0) ? TURN : IDLE;
                    cnt_n   = TURN_LD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RD_ACT: begin
                if (!rd_s) begin
                    if (HOLD_CYCLES > 0) begin
                        state_n = RD_HOLD;
                        cnt_n   = HOLD_LD;
                    end else begin
                        state_n = (TURN_CYCLES > 0) ? TURN : IDLE;
                        cnt_n   = TURN_LD;
                    end
                end
            end
            RD_HOLD: begin
                if (rd_s && !wr_s) begin
                    state_n = RD_ACT;
                end else if (cnt == '0) begin
                    state_n = (TURN_CYCLES > 0) ? TURN : IDLE;
                    cnt_n   = TURN_LD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State register with outputs decoded from the next state, so that the
    // enables come straight from flops and cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wr_en_q    <= (state_n == WR_ACT) || (state_n == WR_HOLD);
            rd_en_q    <= (state_n == RD_ACT) || (state_n == RD_HOLD);
            busy_q     <= (state_n != IDLE);
            conflict_q <= wr_s & rd_s;
        end
    end

`ifdef DDR4_DIR_CTRL_CONFLICT_CNT_EN
    // Count rising edges of the synchronized overlap. The counter saturates
    // at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wr_s && rd_s && !conflict_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign cnt_q = '0;
`endif

    assign bus.wr_en        = wr_en_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.dir_busy     = busy_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_ddr4_dq_dir_ctrl.sv
// Self-checking bench for ddr4_dq_dir_ctrl. A per-cycle vector table runs on a
// default-timing instance with a 2-bit conflict counter. Hand-written
// sequences cover async reset and a zero-hold, zero-turn, single-stage
// instance.
module tb_ddr4_dq_dir_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

`ifdef DDR4_DIR_CTRL_CONFLICT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    ddr4_dq_dir_ctrl_if #(.CNT_W(2)) bus ();
    ddr4_dq_dir_ctrl_if #(.CNT_W(2)) bus2 ();

    ddr4_dq_dir_ctrl #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4),
        .TURN_CYCLES(2),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ddr4_dq_dir_ctrl #(
        .SYNC_STAGES(1),
        .HOLD_CYCLES(0),
        .TURN_CYCLES(0),
        .CNT_W(2)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    typedef struct {
        logic wr;
        logic rd;
        logic ewr;
        logic erd;
        logic ebusy;
        logic econf;
        int   ep;
        int   scen;
    } vec_t;

    typedef struct {
        logic [5:0] exp;
        int         idx;
        int         scen;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [1:0] exp_cnt(input int ep);
        logic [1:0] sat;
        sat = (ep > 3) ? 2'd3 : 2'(ep);
        return CNT_ON ? sat : 2'd0;
    endfunction

    function automatic logic [5:0] outs();
        return {bus.wr_en, bus.rd_en, bus.dir_busy, bus.conflict, bus.conflict_cnt};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input int n, input int scen, input logic wr, input logic rd,
                       input logic ewr, input logic erd, input logic eb, input logic ec,
                       input int ep);
        vec_t v;
        v.wr = wr; v.rd = rd; v.ewr = ewr; v.erd = erd;
        v.ebusy = eb; v.econf = ec; v.ep = ep; v.scen = scen;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic pop_check();
        sb_t e;
        logic [5:0] a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = outs();
            check($sformatf("vec%0d_scen%0d", e.idx, e.scen), a, e.exp);
            check($sformatf("excl%0d", e.idx), {5'd0, a[5] & a[4]}, 6'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] w_in, r_in, e_w, e_r;

        // Scenario 1: write burst, wr 10 cycles
        add(2, 1, 1, 0, 0, 0, 0, 0, 0);
        add(8, 1, 1, 0, 1, 0, 1, 0, 0);
        add(6, 1, 0, 0, 1, 0, 1, 0, 0);
        add(2, 1, 0, 0, 0, 0, 1, 0, 0);
        add(2, 1, 0, 0, 0, 0, 0, 0, 0);
        // Scenario 2: write then read with hold + turn + IDLE decision
        add(2, 2, 1, 0, 0, 0, 0, 0, 0);
        add(3, 2, 1, 0, 1, 0, 1, 0, 0);
        add(1, 2, 0, 0, 1, 0, 1, 0, 0);
        add(5, 2, 0, 1, 1, 0, 1, 0, 0);
        add(2, 2, 0, 1, 0, 0, 1, 0, 0);
        add(1, 2, 0, 1, 0, 0, 0, 0, 0);
        add(6, 2, 0, 1, 0, 1, 1, 0, 0);
        add(6, 2, 0, 0, 0, 1, 1, 0, 0);
        add(2, 2, 0, 0, 0, 0, 1, 0, 0);
        add(2, 2, 0, 0, 0, 0, 0, 0, 0);
        // Scenario 3: conflict from idle, both 5 cycles
        add(2, 3, 1, 1, 0, 0, 0, 0, 0);
        add(3, 3, 1, 1, 0, 0, 0, 1, 1);
        add(2, 3, 0, 0, 0, 0, 0, 1, 1);
        add(2, 3, 0, 0, 0, 0, 0, 0, 1);
        // Scenario 4: same-direction re-request during hold
        add(2, 4, 1, 0, 0, 0, 0, 0, 1);
        add(3, 4, 1, 0, 1, 0, 1, 0, 1);
        add(2, 4, 0, 0, 1, 0, 1, 0, 1);
        add(5, 4, 1, 0, 1, 0, 1, 0, 1);
        add(6, 4, 0, 0, 1, 0, 1, 0, 1);
        add(2, 4, 0, 0, 0, 0, 1, 0, 1);
        add(2, 4, 0, 0, 0, 0, 0, 0, 1);
        // Scenario 5: read request while write holds the bus
        add(2, 5, 1, 0, 0, 0, 0, 0, 1);
        add(1, 5, 1, 0, 1, 0, 1, 0, 1);
        add(2, 5, 1, 1, 1, 0, 1, 0, 1);
        add(1, 5, 1, 1, 1, 0, 1, 1, 2);
        add(2, 5, 1, 0, 1, 0, 1, 1, 2);
        add(2, 5, 0, 0, 1, 0, 1, 0, 2);
        add(4, 5, 0, 0, 1, 0, 1, 0, 2);
        add(2, 5, 0, 0, 0, 0, 1, 0, 2);
        add(2, 5, 0, 0, 0, 0, 0, 0, 2);
        // Scenario 6: three more episodes drive the 2-bit counter to saturation
        for (int p = 0; p < 3; p++) begin
            add(2, 6, 1, 1, 0, 0, 0, 0, 2 + p);
            add(2, 6, 0, 0, 0, 0, 0, 1, 3 + p);
            add(2, 6, 0, 0, 0, 0, 0, 0, 3 + p);
        end

        bus.wr_drive  = 1'b0;
        bus.rd_drive  = 1'b0;
        bus2.wr_drive = 1'b0;
        bus2.rd_drive = 1'b0;

        #1 rst = 1'b1;
        #2;
        check("reset_async", outs(), 6'd0);
        check("reset_async_dut0", {bus2.wr_en, bus2.rd_en, bus2.dir_busy, bus2.conflict, bus2.conflict_cnt}, 6'd0);
        @(negedge clk);
        check("reset_held", outs(), 6'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            sb_t e;
            @(negedge clk);
            pop_check();
            bus.wr_drive = vecs[i].wr;
            bus.rd_drive = vecs[i].rd;
            e.exp  = {vecs[i].ewr, vecs[i].erd, vecs[i].ebusy, vecs[i].econf, exp_cnt(vecs[i].ep)};
            e.idx  = i;
            e.scen = vecs[i].scen;
            sb.push_back(e);
        end
        @(negedge clk);
        pop_check();
        check("sb_drained", 6'(sb.size()), 6'd0);

        // Async reset during RD_HOLD with rd_drive re-asserted
        bus.rd_drive = 1'b1;
        repeat (4) @(negedge clk);
        bus.rd_drive = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_rdhold", {4'd0, bus.rd_en, bus.dir_busy}, 6'b000011);
        bus.rd_drive = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_mid_cycle", {bus.wr_en, bus.rd_en, bus.dir_busy, 1'b0, bus.conflict_cnt}, 6'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rel_edge1", {5'd0, bus.rd_en}, 6'd0);
        @(negedge clk);
        check("rst_rel_edge2", {5'd0, bus.rd_en}, 6'd0);
        @(negedge clk);
        check("rst_rel_edge3", {4'd0, bus.rd_en, bus.dir_busy}, 6'b000011);
        bus.rd_drive = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_settle_idle", outs(), 6'd0);

        // Zero hold / zero turn / single sync stage instance
        w_in = 10'b0000000111;
        r_in = 10'b0001110000;
        e_w  = 10'b0000001110;
        e_r  = 10'b0011100000;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check($sformatf("dut0_cyc%0d", c - 1),
                      {bus2.wr_en, bus2.rd_en, bus2.dir_busy, bus2.conflict, bus2.conflict_cnt},
                      {e_w[c-1], e_r[c-1], e_w[c-1] | e_r[c-1], 3'b000});
            end
            if (c < 10) begin
                bus2.wr_drive = w_in[c];
                bus2.rd_drive = r_in[c];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
